// File: rtl/snn_layer_ctrl_if.sv
// Weight-SRAM read port and shared-neuron datapath bus of snn_layer_ctrl.
// master = layer controller, slave = weight memory + neuron instance.
interface snn_layer_ctrl_if #(
   parameter int W_AW = 7
);
   // w_rd_en is a read strobe: w_data is valid exactly one cycle after it,
   // there is no ready/stall, so the controller never waits on the memory.
   logic            w_rd_en;
   logic [W_AW-1:0] w_addr;
   logic [7:0]      w_data;
   logic [7:0]      nrn_weight;
   logic [8:0]      nrn_v_mem_in;
   logic            nrn_function_sel;
   logic            nrn_spike;
   logic [8:0]      nrn_v_mem_out;

   modport master (
      output w_rd_en, w_addr, nrn_weight, nrn_v_mem_in, nrn_function_sel,
      input  w_data, nrn_spike, nrn_v_mem_out
   );

   modport slave (
      input  w_rd_en, w_addr, nrn_weight, nrn_v_mem_in, nrn_function_sel,
      output w_data, nrn_spike, nrn_v_mem_out
   );
endinterface

// File: rtl/snn_layer_ctrl.sv
// Time-step sequencer for one fully connected spiking layer sharing a single neuron datapath.
// Optional feature: define SNN_SAT_EN to saturate membrane accumulation instead of wrapping.
module snn_layer_ctrl #(
   parameter int N_IN  = 16,
   parameter int N_OUT = 8,
   parameter int W_AW  = $clog2(N_IN*N_OUT)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 i_start,
   input  logic                 i_clear_vmem,
   input  logic [N_IN-1:0]      i_in_spikes,
   output logic                 o_busy,
   output logic                 o_done,
   output logic [N_OUT-1:0]     o_out_spikes,
   output logic [2:0]           o_dbg_state,
   output logic [N_OUT*9-1:0]   o_dbg_vmem,
   snn_layer_ctrl_if.master     io_bus
);

   localparam int I_W = $clog2(N_IN);
   localparam int N_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;
   localparam logic [I_W-1:0] I_LAST = I_W'(N_IN - 1);
   localparam logic [N_W-1:0] N_LAST = N_W'(N_OUT - 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_SCAN  = 3'd1;
   localparam logic [2:0] S_ACCUM = 3'd2;
   localparam logic [2:0] S_DECAY = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   logic [2:0]       r_state;
   logic [I_W-1:0]   r_i;
   logic [N_W-1:0]   r_n;
   logic [N_IN-1:0]  r_spk_q;
   logic [N_OUT-1:0] r_out_spikes;
   logic [8:0]       r_vmem [N_OUT];

   logic             w_last_i;
   logic             w_last_n;
   logic [8:0]       w_cur_vmem;
   logic [8:0]       w_acc_val;
   logic [W_AW-1:0]  w_addr_calc;

   assign w_last_i    = (r_i == I_LAST);
   assign w_last_n    = (r_n == N_LAST);
   assign w_cur_vmem  = r_vmem[r_n];
   assign w_addr_calc = W_AW'(r_n) * W_AW'(N_IN) + W_AW'(r_i);

`ifdef SNN_SAT_EN
   logic [8:0] w_sum;
   logic       w_ovf;

   // Overflow only when both operands share a sign and the 9-bit sum flips it.
   assign w_sum     = w_cur_vmem + {io_bus.w_data[7], io_bus.w_data};
   assign w_ovf     = (w_cur_vmem[8] == io_bus.w_data[7]) && (w_sum[8] != w_cur_vmem[8]);
   assign w_acc_val = !w_ovf ? io_bus.nrn_v_mem_out
                             : (w_cur_vmem[8] ? 9'h100 : 9'h0FF);
`else
   assign w_acc_val = io_bus.nrn_v_mem_out;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_i          <= '0;
         r_n          <= '0;
         r_spk_q      <= '0;
         r_out_spikes <= '0;
         for (int k = 0; k < N_OUT; k++) r_vmem[k] <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_clear_vmem) begin
                  for (int k = 0; k < N_OUT; k++) r_vmem[k] <= '0;
               end else if (i_start) begin
                  r_spk_q      <= i_in_spikes;
                  r_out_spikes <= '0;
                  r_n          <= '0;
                  r_i          <= '0;
                  r_state      <= S_SCAN;
               end
            end
            S_SCAN: begin
               if (r_spk_q[r_i]) begin
                  r_state <= S_ACCUM;
               end else if (w_last_i) begin
                  r_state <= S_DECAY;
               end else begin
                  r_i <= r_i + I_W'(1);
               end
            end
            S_ACCUM: begin
               r_vmem[r_n] <= w_acc_val;
               if (w_last_i) begin
                  r_state <= S_DECAY;
               end else begin
                  r_i     <= r_i + I_W'(1);
                  r_state <= S_SCAN;
               end
            end
            S_DECAY: begin
               r_vmem[r_n]       <= io_bus.nrn_v_mem_out;
               r_out_spikes[r_n] <= io_bus.nrn_spike;
               r_i               <= '0;
               if (w_last_n) begin
                  r_state <= S_DONE;
               end else begin
                  r_n     <= r_n + N_W'(1);
                  r_state <= S_SCAN;
               end
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // The neuron is combinational: drive its operands from the current state only.
   always_comb begin
      io_bus.w_rd_en          = 1'b0;
      io_bus.w_addr           = w_addr_calc;
      io_bus.nrn_weight       = '0;
      io_bus.nrn_function_sel = 1'b0;
      case (r_state)
         S_SCAN:  io_bus.w_rd_en          = r_spk_q[r_i];
         S_ACCUM: io_bus.nrn_weight       = io_bus.w_data;
         S_DECAY: io_bus.nrn_function_sel = 1'b1;
         default: ;
      endcase
   end

   assign io_bus.nrn_v_mem_in = w_cur_vmem;

   always_comb begin
      o_dbg_vmem = '0;
      for (int k = 0; k < N_OUT; k++) o_dbg_vmem[k*9 +: 9] = r_vmem[k];
   end

   assign o_busy       = (r_state != S_IDLE);
   assign o_done       = (r_state == S_DONE);
   assign o_out_spikes = r_out_spikes;
   assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_snn_layer_ctrl.sv
// Bench for snn_layer_ctrl: behavioural neuron + weight SRAM, table vectors, corner sequences, random steps.
module tb_snn_layer_ctrl;
  localparam int N_IN  = 4;
  localparam int N_OUT = 2;
  localparam int W_AW  = 3;

  logic clk;
  logic rst_n;
  logic i_start;
  logic i_clear_vmem;
  logic [N_IN-1:0] i_in_spikes;
  logic o_busy;
  logic o_done;
  logic [N_OUT-1:0] o_out_spikes;
  logic [2:0] o_dbg_state;
  logic [N_OUT*9-1:0] o_dbg_vmem;

  int checks = 0;
  int errors = 0;

  snn_layer_ctrl_if #(.W_AW(W_AW)) bus ();

  snn_layer_ctrl #(.N_IN(N_IN), .N_OUT(N_OUT), .W_AW(W_AW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .i_start(i_start),
    .i_clear_vmem(i_clear_vmem),
    .i_in_spikes(i_in_spikes),
    .o_busy(o_busy),
    .o_done(o_done),
    .o_out_spikes(o_out_spikes),
    .o_dbg_state(o_dbg_state),
    .o_dbg_vmem(o_dbg_vmem),
    .io_bus(bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // neuron stand-in: add weight, or decay by beta/256 then fire against v_th
  int nrn_beta = 255;
  int nrn_vth  = 15;
  int nm_v;
  int nm_d;
  always_comb begin
    nm_v = $signed(bus.nrn_v_mem_in);
    nm_d = 0;
    bus.nrn_spike = 1'b0;
    bus.nrn_v_mem_out = '0;
    if (!bus.nrn_function_sel) begin
      bus.nrn_v_mem_out = bus.nrn_v_mem_in + {bus.nrn_weight[7], bus.nrn_weight};
    end else begin
      nm_d = (nm_v * nrn_beta) >>> 8;
      if (nm_d >= nrn_vth) bus.nrn_spike = 1'b1;
      else bus.nrn_v_mem_out = nm_d[8:0];
    end
  end

  // weight SRAM with one-cycle read latency, plus a log of read addresses
  logic [7:0] wmem [N_IN*N_OUT];
  logic [W_AW-1:0] addr_log[$];
  always @(posedge clk) begin
    if (bus.w_rd_en) bus.w_data <= wmem[bus.w_addr];
  end
  always @(posedge clk) begin
    if (bus.w_rd_en) addr_log.push_back(bus.w_addr);
  end

  // reference model of a whole time step
  int mdl_vmem [N_OUT];
  logic [N_OUT-1:0] mdl_spk;
  logic [W_AW-1:0] exp_q[$];

  task automatic model_clear();
    for (int n = 0; n < N_OUT; n++) mdl_vmem[n] = 0;
  endtask

  task automatic model_step(input logic [N_IN-1:0] sp);
    int v, s, w, prod, d;
    exp_q.delete();
    mdl_spk = '0;
    for (int n = 0; n < N_OUT; n++) begin
      v = mdl_vmem[n];
      for (int i = 0; i < N_IN; i++) begin
        if (sp[i]) begin
          exp_q.push_back(W_AW'(n*N_IN + i));
          w = $signed(wmem[n*N_IN + i]);
          s = v + w;
`ifdef SNN_SAT_EN
          if (s > 255) s = 255;
          if (s < -256) s = -256;
`else
          if (s > 255) s = s - 512;
          if (s < -256) s = s + 512;
`endif
          v = s;
        end
      end
      prod = v * nrn_beta;
      d = (prod >= 0) ? prod / 256 : -((-prod + 255) / 256);
      if (d >= nrn_vth) begin
        mdl_spk[n] = 1'b1;
        v = 0;
      end else begin
        v = d;
      end
      mdl_vmem[n] = v;
    end
  endtask

  // scoreboard helpers
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int vm(input int n);
    logic [8:0] t;
    t = o_dbg_vmem[n*9 +: 9];
    return int'($signed(t));
  endfunction

  task automatic check_addrs();
    check("rd_count", addr_log.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < addr_log.size(); k++)
      check("w_addr", int'(addr_log[k]), int'(exp_q[k]));
  endtask

  function automatic int exp_busy(input logic [N_IN-1:0] sp);
    return N_OUT * (N_IN + $countones(sp) + 1) + 1;
  endfunction

  // driver tasks; all are entered and left just after a falling edge
  task automatic do_clear();
    i_clear_vmem = 1'b1;
    @(negedge clk);
    i_clear_vmem = 1'b0;
    model_clear();
  endtask

  task automatic do_step(input logic [N_IN-1:0] sp, input logic inject,
                         output int busy_len, output int done_at, output int done_cnt);
    addr_log.delete();
    busy_len = 0;
    done_at  = 0;
    done_cnt = 0;
    i_in_spikes = sp;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    i_in_spikes = N_IN'($urandom);
    while (o_busy && busy_len < 200) begin
      busy_len++;
      if (o_done) begin
        done_at = busy_len;
        done_cnt++;
      end
      i_start      = inject && (busy_len == 3);
      i_clear_vmem = inject && (busy_len == 3);
      @(negedge clk);
    end
    i_start = 1'b0;
    i_clear_vmem = 1'b0;
  endtask

  task automatic step_and_score(input string tag, input logic [N_IN-1:0] sp, input logic inject);
    int bl, da, dc;
    model_step(sp);
    do_step(sp, inject, bl, da, dc);
    check({tag, "_busy_len"}, bl, exp_busy(sp));
    check({tag, "_done_at"}, da, exp_busy(sp));
    check({tag, "_done_cnt"}, dc, 1);
    check({tag, "_out_spikes"}, int'(o_out_spikes), int'(mdl_spk));
    for (int n = 0; n < N_OUT; n++) check({tag, "_vmem"}, vm(n), mdl_vmem[n]);
    check_addrs();
  endtask

  typedef struct {
    logic            clr;
    logic [N_IN-1:0] sp;
    int              wval;
    int              beta;
    int              vth;
    logic [N_OUT-1:0] exp_spk;
    int              exp_v0;
    int              exp_v1;
    int              exp_busy;
  } vec_t;

  vec_t vecs [4];

  initial begin
    int bl, da, dc;

    // fire / no fire / P=0 decay only / accumulation overflow
    vecs[0] = '{clr: 1'b1, sp: 4'b0101, wval: 10,  beta: 255, vth: 15,
                exp_spk: 2'b11, exp_v0: 0, exp_v1: 0, exp_busy: 15};
    vecs[1] = '{clr: 1'b1, sp: 4'b0001, wval: 5,   beta: 255, vth: 15,
                exp_spk: 2'b00, exp_v0: 4, exp_v1: 4, exp_busy: 13};
    vecs[2] = '{clr: 1'b0, sp: 4'b0000, wval: 5,   beta: 255, vth: 15,
                exp_spk: 2'b00, exp_v0: 3, exp_v1: 3, exp_busy: 11};
`ifdef SNN_SAT_EN
    vecs[3] = '{clr: 1'b1, sp: 4'b1111, wval: 127, beta: 255, vth: 255,
                exp_spk: 2'b00, exp_v0: 254, exp_v1: 254, exp_busy: 19};
`else
    vecs[3] = '{clr: 1'b1, sp: 4'b1111, wval: 127, beta: 255, vth: 255,
                exp_spk: 2'b00, exp_v0: -4, exp_v1: -4, exp_busy: 19};
`endif

    rst_n = 1'b0;
    i_start = 1'b0;
    i_clear_vmem = 1'b0;
    i_in_spikes = '0;
    for (int a = 0; a < N_IN*N_OUT; a++) wmem[a] = 8'd0;
    model_clear();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check("rst_busy", int'(o_busy), 0);
    check("rst_done", int'(o_done), 0);
    check("rst_out_spikes", int'(o_out_spikes), 0);
    check("rst_w_rd_en", int'(bus.w_rd_en), 0);
    check("rst_vmem0", vm(0), 0);
    check("rst_vmem1", vm(1), 0);

    // table vectors, run back to back
    for (int k = 0; k < 4; k++) begin
      nrn_beta = vecs[k].beta;
      nrn_vth  = vecs[k].vth;
      for (int a = 0; a < N_IN*N_OUT; a++) wmem[a] = vecs[k].wval[7:0];
      if (vecs[k].clr) do_clear();
      model_step(vecs[k].sp);
      do_step(vecs[k].sp, 1'b0, bl, da, dc);
      check("vec_busy_len", bl, vecs[k].exp_busy);
      check("vec_done_at", da, vecs[k].exp_busy);
      check("vec_done_cnt", dc, 1);
      check("vec_out_spikes", int'(o_out_spikes), int'(vecs[k].exp_spk));
      check("vec_vmem0", vm(0), vecs[k].exp_v0);
      check("vec_vmem1", vm(1), vecs[k].exp_v1);
      check_addrs();
    end

    // start and clear_vmem pulsed while busy must be ignored
    nrn_beta = 255;
    nrn_vth  = 60;
    for (int a = 0; a < N_IN*N_OUT; a++) wmem[a] = 8'd7;
    do_clear();
    step_and_score("warm", 4'b0111, 1'b0);
    step_and_score("ignore", 4'b1010, 1'b1);

    // clear_vmem wins over start in IDLE: no step, membranes zeroed
    i_clear_vmem = 1'b1;
    i_start = 1'b1;
    i_in_spikes = 4'b1111;
    @(negedge clk);
    i_clear_vmem = 1'b0;
    i_start = 1'b0;
    model_clear();
    check("clr_start_busy", int'(o_busy), 0);
    check("clr_start_vmem0", vm(0), 0);
    check("clr_start_vmem1", vm(1), 0);
    @(negedge clk);
    check("clr_start_busy_later", int'(o_busy), 0);

    // reset in the middle of a step aborts and zeroes everything
    nrn_vth = 5;
    for (int a = 0; a < N_IN*N_OUT; a++) wmem[a] = 8'd3;
    i_in_spikes = 4'b1111;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    repeat (13) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", int'(o_busy), 0);
    check("midrst_done", int'(o_done), 0);
    check("midrst_out_spikes", int'(o_out_spikes), 0);
    check("midrst_vmem0", vm(0), 0);
    check("midrst_vmem1", vm(1), 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    @(negedge clk);
    nrn_vth = 255;
    step_and_score("post_rst", 4'b1001, 1'b0);

    // randomized steps against the reference model
    for (int r = 0; r < 40; r++) begin
      for (int a = 0; a < N_IN*N_OUT; a++) wmem[a] = 8'($urandom_range(0, 255));
      nrn_beta = $urandom_range(180, 255);
      nrn_vth  = $urandom_range(5, 200);
      if ($urandom_range(0, 7) == 0) do_clear();
      step_and_score("rand", N_IN'($urandom), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
